// File: rtl/tp_link_driver.sv
// tp_link_driver: clocked source for a two-phase dual-rail async link, one token per buffered word.
// Latency: a word pushed at edge E launches at E+1 from IDLE; next launch waits SYNC_STAGES+2 cycles plus ack delay.
// Backpressure: ready_o drops when the FIFO holds DEPTH words; the link is paced by the toggling ack_i.

// tp_link_fifo: generic word FIFO exposing its occupancy to the consumer.
// Latency: push at edge E is visible in o_count and o_pop_dat right after E.
// Backpressure: o_push_rdy low when full; i_pop_rdy must only be raised with o_count != 0.
module tp_link_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push_vld,
    input  logic [WIDTH-1:0]           i_push_dat,
    output logic                       o_push_rdy,
    input  logic                       i_pop_rdy,
    output logic [WIDTH-1:0]           o_pop_dat,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;

    assign o_push_rdy = (r_count != FULL_CNT);
    assign w_push     = i_push_vld & o_push_rdy;
    assign o_pop_dat  = r_mem[r_rptr];
    assign o_count    = r_count;

    // Storage array: written on accepted pushes, contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_push_dat;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (i_pop_rdy) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, i_pop_rdy})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module tp_link_driver #(
    parameter int WIDTH       = 1,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [WIDTH-1:0][1:0] out,
    input  logic                  ack_i,
    output logic                  busy_o,
    output logic                  timeout_o,
    output logic                  proto_err_o
);
    localparam int TCW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TCW-1:0] TMAX = TCW'(TIMEOUT);
    localparam logic [TCW-1:0] TONE = TCW'(1);

    typedef enum logic {S_IDLE, S_WAIT_ACK} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_pop;
    logic [WIDTH-1:0]        w_head;
    logic [$clog2(DEPTH):0]  w_count;
    logic [WIDTH-1:0][1:0]   w_mask;
    logic [WIDTH-1:0][1:0]   r_rails;
    logic [SYNC_STAGES-1:0]  r_ack_sync;
    logic                    w_ack_s;
    logic                    r_phase;
    logic [TCW-1:0]          r_tcnt;
    logic                    r_timeout;
    logic                    r_proto_err;

    tp_link_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push_vld (valid_i),
        .i_push_dat (data_i),
        .o_push_rdy (ready_o),
        .i_pop_rdy  (w_pop),
        .o_pop_dat  (w_head),
        .o_count    (w_count)
    );

    // ack_i is asynchronous; only the last synchronizer flop is used by the logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_i};
        end
    end
    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and pop: launch from IDLE whenever a word is buffered, wait for ack to match phase.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (w_ack_s == r_phase) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Toggle mask: bit value 1 toggles the true rail, 0 toggles the false rail.
    always_comb begin
        w_mask = '0;
        for (int b = 0; b < WIDTH; b++) begin
            w_mask[b] = w_head[b] ? 2'b10 : 2'b01;
        end
    end

    // Rails, phase, timeout counter and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rails     <= '0;
            r_phase     <= 1'b0;
            r_tcnt      <= '0;
            r_timeout   <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rails <= r_rails ^ w_mask;
                r_phase <= ~r_phase;
                r_tcnt  <= '0;
            end
            // An ack edge with nothing outstanding is a receiver fault; launching continues.
            if ((r_state == S_IDLE) && (w_ack_s != r_phase)) begin
                r_proto_err <= 1'b1;
            end
            // Count waiting cycles, saturating at TIMEOUT; the flag sets when the count reaches it.
            if ((r_state == S_WAIT_ACK) && (w_ack_s != r_phase) && (r_tcnt != TMAX)) begin
                r_tcnt <= r_tcnt + TONE;
                if ((TIMEOUT != 0) && (r_tcnt == (TMAX - TONE))) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign out         = r_rails;
    assign busy_o      = (r_state == S_WAIT_ACK) | (w_count != '0);
    assign timeout_o   = r_timeout;
    assign proto_err_o = r_proto_err;
endmodule

// File: tb/tb_tp_link_driver.sv
// Directed bench for tp_link_driver with a behavioural dual-rail receiver that decodes tokens and toggles ack.
// Expected rail patterns and word sequences are hand-computed constants.
module tb_tp_link_driver;
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      data_i = '0;
    logic            valid_i = 1'b0;
    logic            ready_o;
    logic [7:0][1:0] out_w;
    logic            ack_i = 1'b0;
    logic            busy_o;
    logic            timeout_o;
    logic            proto_err_o;

    int n_chk = 0;
    int n_err = 0;

    logic       resp_en = 1'b0;
    logic [15:0] rx_prev = '0;
    logic [7:0] rx_q[$];
    logic       ack_q[$];
    int         launch_q[$];
    int         cyc = 0;
    logic [15:0] mon_prev = '0;
    logic [15:0] saved;

    tp_link_driver #(.WIDTH(8), .DEPTH(4), .SYNC_STAGES(2), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .out         (out_w),
        .ack_i       (ack_i),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o),
        .proto_err_o (proto_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic tok_done(input logic [15:0] cur, input logic [15:0] prv);
        tok_done = 1'b1;
        for (int b = 0; b < 8; b++) begin
            if ((cur[2*b+1] ^ cur[2*b]) == (prv[2*b+1] ^ prv[2*b])) tok_done = 1'b0;
        end
    endfunction

    function automatic logic [7:0] dec(input logic [15:0] cur, input logic [15:0] prv);
        for (int b = 0; b < 8; b++) dec[b] = cur[2*b+1] ^ prv[2*b+1];
    endfunction

    function automatic logic [7:0] rx_at(input int i);
        if (i < rx_q.size()) rx_at = rx_q[i];
        else rx_at = 8'hxx;
    endfunction

    // Receiver: once every pair has flipped parity, decode the word and toggle ack 100 ns later.
    always @(negedge clk) begin
        if (resp_en && !rst && tok_done(out_w, rx_prev)) begin
            rx_q.push_back(dec(out_w, rx_prev));
            rx_prev = out_w;
            #100;
            ack_i = ~ack_i;
            ack_q.push_back(ack_i);
        end
    end

    // Launch monitor: records the cycle of every rail change outside reset.
    always @(negedge clk) begin
        cyc++;
        if (!rst && (out_w !== mon_prev)) launch_q.push_back(cyc);
        mon_prev = out_w;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        data_i  = d;
        valid_i = 1'b1;
        @(posedge clk);
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!busy_o) break;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        ack_i   = 1'b0;
        rx_prev = '0;
        valid_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rx_q.delete();
        ack_q.delete();
        launch_q.delete();
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_out", out_w, 16'h0000);
        chk("rst_ready", ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_proto", proto_err_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single word 0xA5
        resp_en = 1'b1;
        push(8'hA5);
        @(negedge clk);
        valid_i = 1'b0;
        chk("a5_pre_launch_out", out_w, 16'h0000);
        chk("a5_pre_launch_busy", busy_o, 1);
        @(negedge clk);
        chk("a5_rails", out_w, 16'h9966);
        wait_idle(100);
        chk("a5_busy_done", busy_o, 0);
        chk("a5_decoded", rx_at(0), 8'hA5);
        chk("a5_ack", ack_i, 1);

        // Back-to-back 0x00, 0xFF, 0x3C from reset
        do_reset();
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        @(negedge clk);
        valid_i = 1'b0;
        wait_idle(300);
        chk("b2b_busy_done", busy_o, 0);
        chk("b2b_count", rx_q.size(), 3);
        chk("b2b_w0", rx_at(0), 8'h00);
        chk("b2b_w1", rx_at(1), 8'hFF);
        chk("b2b_w2", rx_at(2), 8'h3C);
        chk("b2b_ack_levels", {ack_q.size() > 2 ? {ack_q[0], ack_q[1], ack_q[2]} : 3'bxxx}, 3'b101);
        chk("b2b_final_ack", ack_i, 1);
        chk("b2b_rails", out_w, 16'hA55A);
        chk("b2b_launches", launch_q.size(), 3);
        for (int i = 1; i < 3; i++) begin
            chk("b2b_gap", (launch_q.size() > i) && (launch_q[i] - launch_q[i-1] >= 4), 1);
        end

        // FIFO full with ack held
        do_reset();
        resp_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("full_rdy_before_push", ready_o, 1);
            data_i  = 8'(8'h11 * (i + 1));
            valid_i = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        data_i = 8'h66;
        chk("full_ready_low", ready_o, 0);
        repeat (3) @(negedge clk);
        chk("full_still_held", ready_o, 0);
        chk("full_one_token", out_w, 16'h5656);
        valid_i = 1'b0;
        resp_en = 1'b1;
        wait_idle(500);
        chk("full_busy_done", busy_o, 0);
        chk("full_count", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk("full_order", rx_at(i), 8'(8'h11 * (i + 1)));
        end

        // Timeout with ack withheld
        do_reset();
        resp_en = 1'b0;
        push(8'h5A);
        repeat (16) @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        chk("to_not_yet", timeout_o, 0);
        @(negedge clk);
        chk("to_set", timeout_o, 1);
        repeat (10) @(negedge clk);
        chk("to_sticky", timeout_o, 1);
        chk("to_busy_wait", busy_o, 1);
        resp_en = 1'b1;
        wait_idle(100);
        chk("to_busy_done", busy_o, 0);
        chk("to_decoded", rx_at(0), 8'h5A);
        chk("to_sticky_after_ack", timeout_o, 1);

        // Spurious ack in IDLE
        resp_en = 1'b0;
        @(negedge clk);
        saved = out_w;
        chk("sp_proto_before", proto_err_o, 0);
        ack_i = ~ack_i;
        repeat (2) @(negedge clk);
        chk("sp_proto_2edges", proto_err_o, 0);
        @(negedge clk);
        chk("sp_proto_3edges", proto_err_o, 1);
        chk("sp_out_unchanged", out_w, saved);
        chk("sp_busy", busy_o, 0);

        // Restore ack agreement, then reset while waiting with 2 words buffered
        ack_i = ~ack_i;
        repeat (4) @(negedge clk);
        push(8'hAA);
        push(8'hBB);
        push(8'hCC);
        @(negedge clk);
        valid_i = 1'b0;
        chk("mid_busy", busy_o, 1);
        #2;
        rst     = 1'b1;
        ack_i   = 1'b0;
        rx_prev = '0;
        #1;
        chk("mid_out", out_w, 16'h0000);
        chk("mid_ready", ready_o, 1);
        chk("mid_busy_clr", busy_o, 0);
        chk("mid_timeout", timeout_o, 0);
        chk("mid_proto", proto_err_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rx_q.delete();
        resp_en = 1'b1;
        push(8'h01);
        @(negedge clk);
        valid_i = 1'b0;
        wait_idle(100);
        chk("post_busy_done", busy_o, 0);
        chk("post_count", rx_q.size(), 1);
        chk("post_decoded", rx_at(0), 8'h01);
        chk("post_rails", out_w, 16'h5556);
        chk("post_ack", ack_i, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
